// File: rtl/ssd_scan_ctrl.sv
// rtl/ssd_scan_ctrl.sv - N-digit multiplexed seven-segment scanner with blanking and dp.
// Optional SSD_BCD_EN: sequential double-dabble binary-to-BCD conversion of the loaded value.
module ssd_scan_ctrl #(
  parameter int NUM_DIGITS    = 8,
  parameter int SCAN_DIV_BITS = 18
) (
  input  logic                    ClkPort,
  input  logic                    Reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic                    enable,
  output logic                    busy,
  output logic                    ovf,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              seg
);
  localparam int W  = 4 * NUM_DIGITS;
  localparam int IW = $clog2(NUM_DIGITS);

  logic [SCAN_DIV_BITS-1:0] pre_q, pre_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [W-1:0]             disp_q, disp_d;
  logic [NUM_DIGITS-1:0]    dpr_q, dpr_d;
  logic [NUM_DIGITS-1:0]    an_q, an_d;
  logic [7:0]               seg_q, seg_d;
  logic                     ovf_q, ovf_d;
  logic [3:0]               nib;
  logic [NUM_DIGITS-1:0]    zero_up;
  logic                     zacc;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b0000001;
      4'h1: glyph = 7'b1001111;
      4'h2: glyph = 7'b0010010;
      4'h3: glyph = 7'b0000110;
      4'h4: glyph = 7'b1001100;
      4'h5: glyph = 7'b0100100;
      4'h6: glyph = 7'b0100000;
      4'h7: glyph = 7'b0001111;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0000100;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b1100000;
      4'hC: glyph = 7'b0110001;
      4'hD: glyph = 7'b1000010;
      4'hE: glyph = 7'b0110000;
      default: glyph = 7'b0111000;
    endcase
  endfunction

  always_comb begin
    pre_d = pre_q + 1'b1;
    idx_d = idx_q;
    if (&pre_q) begin
      idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // zero_up[i] is set when digit i and every digit above it are zero
  always_comb begin
    zacc    = 1'b1;
    zero_up = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zacc       = zacc & (disp_q[4*i +: 4] == 4'h0);
      zero_up[i] = zacc;
    end
  end

  always_comb begin
    nib   = disp_q[{idx_q, 2'b00} +: 4];
    an_d  = '1;
    seg_d = 8'hFF;
    if (enable) begin
      an_d[idx_q] = 1'b0;
    end
    if (ovf_q) begin
      seg_d[7:1] = 7'b1111110;
    end else if (blank_lz && (idx_q != '0) && zero_up[idx_q]) begin
      seg_d[7:1] = 7'b1111111;
    end else begin
      seg_d[7:1] = glyph(nib);
    end
    seg_d[0] = ~dpr_q[idx_q];
  end

`ifdef SSD_BCD_EN
  localparam int CW = $clog2(W);

  logic                  busy_q, busy_d;
  logic [W-1:0]          bin_q, bin_d;
  logic [W-1:0]          bcd_q, bcd_d;
  logic [W-1:0]          adj;
  logic [NUM_DIGITS-1:0] dpp_q, dpp_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  oacc_q, oacc_d;

  // One double-dabble step per cycle: add 3 to digits >= 5, then shift in the next binary bit
  always_comb begin
    adj = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    end
    busy_d = busy_q;
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    dpp_d  = dpp_q;
    cnt_d  = cnt_q;
    oacc_d = oacc_q;
    disp_d = disp_q;
    dpr_d  = dpr_q;
    ovf_d  = ovf_q;
    if (busy_q) begin
      bcd_d  = {adj[W-2:0], bin_q[W-1]};
      bin_d  = {bin_q[W-2:0], 1'b0};
      oacc_d = oacc_q | adj[W-1];
      cnt_d  = cnt_q + 1'b1;
      if (cnt_q == CW'(W - 1)) begin
        busy_d = 1'b0;
        disp_d = bcd_d;
        dpr_d  = dpp_q;
        ovf_d  = oacc_d;
      end
    end else if (load) begin
      busy_d = 1'b1;
      bin_d  = value;
      bcd_d  = '0;
      dpp_d  = dp;
      cnt_d  = '0;
      oacc_d = 1'b0;
    end
  end

  always_ff @(posedge ClkPort) begin
    if (Reset) begin
      busy_q <= 1'b0;
      bin_q  <= '0;
      bcd_q  <= '0;
      dpp_q  <= '0;
      cnt_q  <= '0;
      oacc_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      dpp_q  <= dpp_d;
      cnt_q  <= cnt_d;
      oacc_q <= oacc_d;
    end
  end

  assign busy = busy_q;
`else
  always_comb begin
    disp_d = disp_q;
    dpr_d  = dpr_q;
    ovf_d  = 1'b0;
    if (load) begin
      disp_d = value;
      dpr_d  = dp;
    end
  end

  assign busy = 1'b0;
`endif

  always_ff @(posedge ClkPort) begin
    if (Reset) begin
      pre_q  <= '0;
      idx_q  <= '0;
      disp_q <= '0;
      dpr_q  <= '0;
      an_q   <= '1;
      seg_q  <= 8'hFF;
      ovf_q  <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      idx_q  <= idx_d;
      disp_q <= disp_d;
      dpr_q  <= dpr_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      ovf_q  <= ovf_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb/tb_ssd_scan_ctrl.sv - directed and random stimulus against a cycle-count reference model.
module tb_ssd_scan_ctrl;
  localparam int N  = 4;
  localparam int DB = 2;

  logic        ClkPort = 1'b0;
  logic        Reset;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        load;
  logic        blank_lz;
  logic        enable;
  logic        busy;
  logic        ovf;
  logic [3:0]  an;
  logic [7:0]  seg;

  int n_assert = 0;
  int n_fail   = 0;

  logic [6:0] glyph_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  int          t_m;
  logic [15:0] disp_m;
  logic [3:0]  dp_m;
  logic        ovf_m;
  int          busy_rem;
  logic [15:0] pend_v;
  logic [3:0]  pend_dp;
  logic [3:0]  exp_an;
  logic [7:0]  exp_seg;

  ssd_scan_ctrl #(.NUM_DIGITS(N), .SCAN_DIV_BITS(DB)) dut (
    .ClkPort (ClkPort),
    .Reset   (Reset),
    .value   (value),
    .dp      (dp),
    .load    (load),
    .blank_lz(blank_lz),
    .enable  (enable),
    .busy    (busy),
    .ovf     (ovf),
    .an      (an),
    .seg     (seg)
  );

  always #5 ClkPort = ~ClkPort;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r = r | (16'((v / (10 ** i)) % 10) << (4 * i));
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Predict the pins from the state held before this edge, then apply this edge's updates
  task automatic tick();
    int d;
    logic [3:0] nib;
    if (Reset) begin
      exp_an   = 4'hF;
      exp_seg  = 8'hFF;
      t_m      = 0;
      disp_m   = '0;
      dp_m     = '0;
      ovf_m    = 1'b0;
      busy_rem = 0;
    end else begin
      d       = (t_m / (2 ** DB)) % N;
      exp_an  = enable ? ~(4'b1 << d) : 4'hF;
      nib     = 4'(disp_m >> (4 * d));
      if (ovf_m) exp_seg[7:1] = 7'b1111110;
      else if (blank_lz && d > 0 && (disp_m >> (4 * d)) == 16'h0) exp_seg[7:1] = 7'b1111111;
      else exp_seg[7:1] = glyph_tab[nib];
      exp_seg[0] = ~dp_m[d];
      t_m++;
`ifdef SSD_BCD_EN
      if (busy_rem > 0) begin
        busy_rem--;
        if (busy_rem == 0) begin
          ovf_m  = (pend_v > 16'd9999);
          disp_m = to_bcd(int'(pend_v));
          dp_m   = pend_dp;
        end
      end else if (load) begin
        busy_rem = 16;
        pend_v   = value;
        pend_dp  = dp;
      end
`else
      if (load) begin
        disp_m = value;
        dp_m   = dp;
      end
`endif
    end
    @(posedge ClkPort);
    @(negedge ClkPort);
    chk("an", 16'(an), 16'(exp_an));
    chk("seg", 16'(seg), 16'(exp_seg));
    chk("busy", 16'(busy), 16'(busy_rem > 0));
    chk("ovf", 16'(ovf), 16'(ovf_m));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp    = d;
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  initial begin
    Reset    = 1'b1;
    value    = '0;
    dp       = '0;
    load     = 1'b0;
    blank_lz = 1'b0;
    enable   = 1'b1;
    @(negedge ClkPort);
    run(3);
    Reset = 1'b0;
    tick();
    chk("first_digit_seg", 16'(seg), 16'h0003);
    chk("first_digit_an", 16'(an), 16'h000E);
    run(19);

`ifndef SSD_BCD_EN
    do_load(16'h1A2F, 4'b0100);
    run(20);
    blank_lz = 1'b1;
    do_load(16'h0030, 4'b0000);
    run(20);
    blank_lz = 1'b0;
    run(20);
    enable = 1'b0;
    run(8);
    enable = 1'b1;
    do_load(16'h0000, 4'b1111);
    blank_lz = 1'b1;
    run(20);
    Reset = 1'b1;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    Reset = 1'b0;
    run(10);
`else
    do_load(16'd1234, 4'b0000);
    run(5);
    do_load(16'd9999, 4'b1111);
    run(26);
    do_load(16'd12345, 4'b0010);
    run(30);
    do_load(16'd5000, 4'b0000);
    run(6);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    blank_lz = 1'b1;
    do_load(16'd42, 4'b0000);
    run(30);
    blank_lz = 1'b0;
    run(16);
`endif

    for (int i = 0; i < 600; i++) begin
      load  = ($urandom_range(0, 7) == 0);
`ifdef SSD_BCD_EN
      value = ($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'($urandom_range(0, 9999));
`else
      value = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
`endif
      dp = 4'($urandom);
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
      enable = ($urandom_range(0, 9) != 0);
      Reset  = ($urandom_range(0, 99) == 0);
      tick();
    end
    Reset = 1'b0;
    load  = 1'b0;
    run(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
